uart_rx_ovs: RTL

Parametrised UART receiver with an integrated oversampling baud generator. It replaces the separate receiver/baud-unit pair. Adds configurable data width, parity, stop bits, majority-vote sampling, glitch rejection, a ready/valid output handshake and error flags. Sits between the pad-side rx line and the byte-level consumer (FIFO or command parser).

---
 rtl/uart_rx_ovs.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ovs.sv
// UART receiver with built-in oversampling baud generator, 2-of-3
// majority sampling, optional parity, 1/2 stop bits and ready/valid output.
module uart_rx_ovs #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int TICK_DIV    = 54,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] SMP0      = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] SMP1      = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] SMP2      = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, BRK
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [TW-1:0]          tick_cnt;
  logic [OW-1:0]          os_cnt;
  logic                   tick;
  logic                   start_det;
  logic                   resolve;
  logic                   bit_end;
  logic                   smp0, smp1;
  logic                   maj;
  logic [BW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_acc;
  logic                   par_bad;
  logic                   deliver;
  logic                   ferr_set;
  logic                   accept;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Preset high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  assign start_det = (state == IDLE) && !rxs;
  assign tick      = (tick_cnt == TICK_LAST);
  assign resolve   = tick && (os_cnt == SMP2);
  assign bit_end   = tick && (os_cnt == OS_LAST);
  assign maj       = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);

  always_ff @(posedge clk) begin
    if (reset || start_det) tick_cnt <= '0;
    else if (tick)          tick_cnt <= '0;
    else                    tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || start_det) os_cnt <= '0;
    else if (bit_end)       os_cnt <= '0;
    else if (tick)          os_cnt <= os_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp0 <= 1'b0;
      smp1 <= 1'b0;
    end else if (tick) begin
      if (os_cnt == SMP0) smp0 <= rxs;
      if (os_cnt == SMP1) smp1 <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_det) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_bad  <= 1'b0;
    end else begin
      if (state == DATA && resolve) begin
        shreg   <= {maj, shreg[DATA_BITS-1:1]};
        par_acc <= par_acc ^ maj;
      end
      if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
      if (state == STOP && bit_end) stop_idx <= stop_idx + 1'b1;
      if (state == PAR && resolve)
        par_bad <= (PARITY == 1) ? !(par_acc ^ maj)
                                 : (par_acc ^ maj);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!rxs) state_nx = START;
      START: begin
        if (resolve && maj) state_nx = IDLE;
        else if (bit_end)   state_nx = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == BIT_LAST)
          state_nx = (PARITY != 0) ? PAR : STOP;
      end
      PAR:   if (bit_end) state_nx = STOP;
      STOP: begin
        if (resolve && !maj)                   state_nx = BRK;
        else if (resolve && stop_idx == STOP_LAST) state_nx = IDLE;
      end
      BRK:   if (rxs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    deliver  = (state == STOP) && resolve && maj &&
               (stop_idx == STOP_LAST);
    ferr_set = (state == STOP) && resolve && !maj;
  end

  assign accept = !rx_valid || rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= deliver && !accept;
      if (deliver && accept) begin
        rx_data    <= shreg;
        parity_err <= (PARITY != 0) && par_bad;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
